// File: rtl/controller_sseg_driver.sv
// rtl/controller_sseg_driver.sv - multiplexed seven-segment driver with shadow/active register banks
module controller_sseg_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  chipselect,
    input  logic [1:0]            address,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [1:0]            sseg_reset,
    output logic [7:0]            seg_n,
    output logic [NUM_DIGITS-1:0] dig_n
);

    localparam int             PW       = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]  PRESC_TC = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]  DEAD_C   = PW'(DEAD_CYCLES);
    localparam logic [1:0]     IDX_LAST = 2'(NUM_DIGITS - 1);

    // Scan position
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;

    // Shadow bank (software-visible) and active bank (displayed)
    logic [15:0]   shd_data_q, shd_data_d;
    logic [3:0]    shd_dp_q, shd_dp_d;
    logic [3:0]    shd_blank_q, shd_blank_d;
    logic [15:0]   act_data_q, act_data_d;
    logic [3:0]    act_dp_q, act_dp_d;
    logic [3:0]    act_blank_q, act_blank_d;
    logic          pending_q, pending_d;
    logic          enable_q, enable_d;

    // Registered pad drivers
    logic [7:0]            seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;

    logic       hold, clr, presc_tc, frame_wrap, bus_wr, drive;
    logic [3:0] nibble;
    logic [3:0] dig4;
    logic       unused_wdata;

    assign unused_wdata = ^writedata[31:16];

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Prescaler and digit index; scan hold parks both at zero
    always_comb begin
        hold       = sseg_reset[0];
        clr        = sseg_reset[1];
        presc_tc   = (presc_q == PRESC_TC);
        frame_wrap = ~hold & presc_tc & (idx_q == IDX_LAST);
        presc_d    = presc_q + 1'b1;
        idx_d      = idx_q;
        if (hold) begin
            presc_d = '0;
            idx_d   = 2'd0;
        end else if (presc_tc) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
        end
    end

    // Register banks: frame-wrap commit uses the pre-write shadow, clear overrides everything
    always_comb begin
        bus_wr      = chipselect & ~write_n & ~clr;
        shd_data_d  = shd_data_q;
        shd_dp_d    = shd_dp_q;
        shd_blank_d = shd_blank_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        pending_d   = pending_q;
        enable_d    = enable_q;
        if (frame_wrap && pending_q) begin
            act_data_d  = shd_data_q;
            act_dp_d    = shd_dp_q;
            act_blank_d = shd_blank_q;
            pending_d   = 1'b0;
        end
        if (bus_wr) begin
            case (address)
                2'd0: begin
                    shd_data_d = writedata[15:0];
                    pending_d  = 1'b1;
                end
                2'd1: begin
                    shd_dp_d    = writedata[3:0];
                    shd_blank_d = writedata[7:4];
                    pending_d   = 1'b1;
                end
                2'd2: enable_d = writedata[0];
                default: ;
            endcase
        end
        if (clr) begin
            shd_data_d  = '0;
            shd_dp_d    = '0;
            shd_blank_d = '0;
            act_data_d  = '0;
            act_dp_d    = '0;
            act_blank_d = '0;
            pending_d   = 1'b0;
            enable_d    = 1'b0;
        end
    end

    // Segment and digit drive for the current slot, registered one clock later
    always_comb begin
        nibble = act_data_q[{idx_q, 2'b00} +: 4];
        drive  = enable_q & ~hold & (presc_q >= DEAD_C) & ~act_blank_q[idx_q];
        dig4   = 4'hF;
        if (drive) begin
            dig4[idx_q] = 1'b0;
        end
        seg_n_d = drive ? {~act_dp_q[idx_q], hex7(nibble)} : 8'hFF;
        dig_n_d = dig4[NUM_DIGITS-1:0];
    end

    // Zero-wait-state read mux
    always_comb begin
        case (address)
            2'd0:    readdata = {16'b0, shd_data_q};
            2'd1:    readdata = {24'b0, shd_blank_q, shd_dp_q};
            2'd2:    readdata = {31'b0, enable_q};
            default: readdata = {27'b0, pending_q, 2'b00, idx_q};
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            idx_q       <= 2'd0;
            shd_data_q  <= '0;
            shd_dp_q    <= '0;
            shd_blank_q <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '0;
            pending_q   <= 1'b0;
            enable_q    <= 1'b0;
            seg_n_q     <= 8'hFF;
            dig_n_q     <= '1;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            shd_data_q  <= shd_data_d;
            shd_dp_q    <= shd_dp_d;
            shd_blank_q <= shd_blank_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            seg_n_q     <= seg_n_d;
            dig_n_q     <= dig_n_d;
        end
    end

    assign seg_n = seg_n_q;
    assign dig_n = dig_n_q;

endmodule
